ripple_sequencer: RTL and testbench

- Time-shares one chunked ripple adder/comparator between two requesters.
- Each operation takes two WIDTH-bit operands and processes them CHUNK bits per clock, least-significant chunk first, carrying between chunks.
- Returns the sum, the carry-out and an equality flag.
- Sits between requesting blocks and the ripple datapath; owns round-robin arbitration and operation sequencing.

---
 rtl/ripple_sequencer_if.sv | 45 ++++
 rtl/ripple_sequencer.sv | 117 +++++++++++
 tb/tb_ripple_sequencer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ripple_sequencer_if.sv
// Request/result bundle between the requesters and ripple_sequencer.
// RIPPLE_SEQ_STATS_EN adds the out_op_count completed-operation counter.
interface ripple_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             in_req0;
  logic             in_req1;
  logic [WIDTH-1:0] in_a0;
  logic [WIDTH-1:0] in_b0;
  logic [WIDTH-1:0] in_a1;
  logic [WIDTH-1:0] in_b1;
  logic             out_gnt0;
  logic             out_gnt1;
  logic             out_done;
  logic             out_owner;
  logic [WIDTH-1:0] out_sum;
  logic             out_q1;
  logic             out_q2;
  logic             out_busy;
`ifdef RIPPLE_SEQ_STATS_EN
  logic [15:0]      out_op_count;

  modport master (
    output in_req0, in_req1, in_a0, in_b0, in_a1, in_b1,
    input  out_gnt0, out_gnt1, out_done, out_owner, out_sum, out_q1, out_q2, out_busy,
    input  out_op_count
  );

  modport slave (
    input  in_req0, in_req1, in_a0, in_b0, in_a1, in_b1,
    output out_gnt0, out_gnt1, out_done, out_owner, out_sum, out_q1, out_q2, out_busy,
    output out_op_count
  );
`else
  modport master (
    output in_req0, in_req1, in_a0, in_b0, in_a1, in_b1,
    input  out_gnt0, out_gnt1, out_done, out_owner, out_sum, out_q1, out_q2, out_busy
  );

  modport slave (
    input  in_req0, in_req1, in_a0, in_b0, in_a1, in_b1,
    output out_gnt0, out_gnt1, out_done, out_owner, out_sum, out_q1, out_q2, out_busy
  );
`endif
endinterface

// File: rtl/ripple_sequencer.sv
// Round-robin shared chunked ripple adder/comparator for two requesters.
// Optional RIPPLE_SEQ_STATS_EN: 16-bit count of completed operations.
module ripple_sequencer #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic                 in_clk,
  input logic                 in_reset_n,
  ripple_sequencer_if.slave   bus
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {IDLE, RIPPLE, DONE} state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic             eq;
  logic [IDX_W-1:0] idx;
  logic             last_owner;
  logic             win1;
  logic             any_req;
  logic             last_chunk;
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK:0]   chunk_sum;
  logic             chunk_eq;

  // With both requesting, the one that did not win last time goes next.
  always_comb begin
    any_req    = bus.in_req0 || bus.in_req1;
    win1       = bus.in_req1 && (!bus.in_req0 || !last_owner);
    chunk_a    = op_a[idx*CHUNK +: CHUNK];
    chunk_b    = op_b[idx*CHUNK +: CHUNK];
    chunk_sum  = {1'b0, chunk_a} + {1'b0, chunk_b} + (CHUNK+1)'(carry);
    chunk_eq   = (chunk_a == chunk_b);
    last_chunk = (idx == LAST_IDX);
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) state <= IDLE;
    else             state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = RIPPLE;
      RIPPLE:  if (last_chunk) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.out_busy = (state != IDLE);
    bus.out_done = (state == DONE);
    bus.out_gnt0 = (state == RIPPLE) && (idx == '0) && !bus.out_owner;
    bus.out_gnt1 = (state == RIPPLE) && (idx == '0) &&  bus.out_owner;
  end

  // Capture in IDLE, one chunk per RIPPLE edge; flags land on the DONE entry edge.
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      op_a          <= '0;
      op_b          <= '0;
      carry         <= 1'b0;
      eq            <= 1'b1;
      idx           <= '0;
      last_owner    <= 1'b1;
      bus.out_owner <= 1'b0;
      bus.out_sum   <= '0;
      bus.out_q1    <= 1'b0;
      bus.out_q2    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            op_a          <= win1 ? bus.in_a1 : bus.in_a0;
            op_b          <= win1 ? bus.in_b1 : bus.in_b0;
            carry         <= 1'b0;
            eq            <= 1'b1;
            idx           <= '0;
            last_owner    <= win1;
            bus.out_owner <= win1;
          end
        end
        RIPPLE: begin
          bus.out_sum[idx*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
          carry <= chunk_sum[CHUNK];
          eq    <= eq && chunk_eq;
          if (last_chunk) begin
            idx        <= '0;
            bus.out_q1 <= chunk_sum[CHUNK];
            bus.out_q2 <= eq && chunk_eq;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RIPPLE_SEQ_STATS_EN
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n)                       bus.out_op_count <= 16'd0;
    else if (state == RIPPLE && last_chunk) bus.out_op_count <= bus.out_op_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ripple_sequencer.sv
// Scoreboard bench for ripple_sequencer: driver predicts arbitration and results
// with plain arithmetic; an independent monitor checks each out_done pulse.
module tb_ripple_sequencer;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int N     = WIDTH / CHUNK;

  typedef struct {
    bit               owner;
    logic [WIDTH-1:0] sum;
    bit               carry;
    bit               eq;
    int               done_cycle;
  } exp_t;

  logic in_clk = 1'b0;
  logic in_reset_n = 1'b1;

  ripple_sequencer_if #(.WIDTH(WIDTH)) bus ();

  ripple_sequencer #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .in_clk     (in_clk),
    .in_reset_n (in_reset_n),
    .bus        (bus)
  );

  always #5 in_clk = ~in_clk;

  exp_t exp_q[$];
  int   cycle = 0;
  int   checks_run = 0;
  int   checks_passed = 0;
  int   ops_done = 0;
  bit   model_last_owner = 1'b1;

  initial forever begin
    @(posedge in_clk);
    cycle++;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks_run++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_flags"},
                {bus.out_gnt0, bus.out_gnt1, bus.out_done, bus.out_owner,
                 bus.out_q1, bus.out_q2, bus.out_busy}, 64'd0);
    checkOutput({tag, "_sum"}, bus.out_sum, 64'd0);
  endtask

  // Monitor: every out_done must match the oldest outstanding prediction.
  initial forever begin
    exp_t e;
    @(negedge in_clk);
    if (in_reset_n && bus.out_done) begin
      ops_done++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("sum",     bus.out_sum,   e.sum);
        checkOutput("carry",   bus.out_q1,    e.carry);
        checkOutput("eq",      bus.out_q2,    e.eq);
        checkOutput("owner",   bus.out_owner, e.owner);
        checkOutput("busy",    bus.out_busy,  64'd1);
        checkOutput("latency", cycle,         e.done_cycle);
      end
    end
  end

  // Raise the requested reqs, then serve grants until every raised req was granted.
  task automatic applyStimulus(input bit r0, input bit r1,
                               input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                               input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1);
    bit   p0, p1, pred;
    int   first_gnt, wait_cycles;
    exp_t e;
    @(negedge in_clk);
    bus.in_a0 = a0; bus.in_b0 = b0; bus.in_a1 = a1; bus.in_b1 = b1;
    bus.in_req0 = r0; bus.in_req1 = r1;
    p0 = r0; p1 = r1;
    first_gnt = -1;
    wait_cycles = 0;
    while (p0 || p1) begin
      @(negedge in_clk);
      wait_cycles++;
      if (wait_cycles > 4 * (N + 2) + 4) begin
        checkOutput("gnt_timeout", 64'd1, 64'd0);
        bus.in_req0 = 1'b0;
        bus.in_req1 = 1'b0;
        break;
      end
      if (bus.out_gnt0 || bus.out_gnt1) begin
        pred = (p0 && p1) ? !model_last_owner : p1;
        checkOutput("gnt_winner", {bus.out_gnt1, bus.out_gnt0}, pred ? 64'd2 : 64'd1);
        e.owner = pred;
        if (pred) begin
          {e.carry, e.sum} = {1'b0, a1} + {1'b0, b1};
          e.eq = (a1 == b1);
        end else begin
          {e.carry, e.sum} = {1'b0, a0} + {1'b0, b0};
          e.eq = (a0 == b0);
        end
        e.done_cycle = cycle + N;
        exp_q.push_back(e);
        if (first_gnt >= 0) checkOutput("gnt_gap", cycle - first_gnt, N + 2);
        first_gnt = cycle;
        model_last_owner = pred;
        if (bus.out_gnt0) begin bus.in_req0 = 1'b0; p0 = 1'b0; end
        if (bus.out_gnt1) begin bus.in_req1 = 1'b0; p1 = 1'b0; end
        wait_cycles = 0;
      end
    end
  endtask

  task automatic waitDrain();
    int t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      @(negedge in_clk);
      t++;
    end
    repeat (2) @(negedge in_clk);
    checkOutput("drain", exp_q.size(), 64'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] ra0, rb0, ra1, rb1;
    int pattern;
    bus.in_req0 = 1'b0; bus.in_req1 = 1'b0;
    bus.in_a0 = '0; bus.in_b0 = '0; bus.in_a1 = '0; bus.in_b1 = '0;

    #2 in_reset_n = 1'b0;
    repeat (2) @(negedge in_clk);
    checkIdle("reset");
`ifdef RIPPLE_SEQ_STATS_EN
    checkOutput("op_count_reset", bus.out_op_count, 64'd0);
`endif
    in_reset_n = 1'b1;

    // Contention first: requester 0 must win the initial tie.
    applyStimulus(1'b1, 1'b1, 32'h11111111, 32'h22222222, 32'hAAAAAAAA, 32'h55555555);
    applyStimulus(1'b1, 1'b0, 32'h0000FFFF, 32'h0000F7DA, '0, '0);
    applyStimulus(1'b0, 1'b1, '0, '0, 32'hFFFFFFFF, 32'h00000001);
    applyStimulus(1'b1, 1'b0, 32'h12345678, 32'h12345678, '0, '0);

    for (int i = 0; i < 24; i++) begin
      pattern = $urandom_range(1, 3);
      ra0 = $urandom; rb0 = $urandom; ra1 = $urandom; rb1 = $urandom;
      if ($urandom_range(0, 3) == 0) rb0 = ra0;
      if ($urandom_range(0, 3) == 0) rb1 = ra1;
      if ($urandom_range(0, 5) == 0) ra0 = '1;
      applyStimulus(pattern[0], pattern[1], ra0, rb0, ra1, rb1);
    end
    waitDrain();
`ifdef RIPPLE_SEQ_STATS_EN
    checkOutput("op_count", bus.out_op_count, 64'(ops_done[15:0]));
`endif

    // Abort two edges after capture; the queued prediction must never complete.
    applyStimulus(1'b1, 1'b0, 32'hCAFEF00D, 32'h01234567, '0, '0);
    @(posedge in_clk);
    @(posedge in_clk);
    #1 in_reset_n = 1'b0;
    #1 checkIdle("abort");
`ifdef RIPPLE_SEQ_STATS_EN
    checkOutput("op_count_abort", bus.out_op_count, 64'd0);
`endif
    exp_q.delete();
    model_last_owner = 1'b1;
    ops_done = 0;
    @(negedge in_clk);
    @(negedge in_clk);
    in_reset_n = 1'b1;

    applyStimulus(1'b1, 1'b0, 32'h80000000, 32'h80000000, '0, '0);
    applyStimulus(1'b1, 1'b1, 32'h000000FF, 32'h00000001, 32'h00FF00FF, 32'h0F0F0F0F);
    waitDrain();
`ifdef RIPPLE_SEQ_STATS_EN
    checkOutput("op_count_after", bus.out_op_count, 64'(ops_done[15:0]));
`endif

    $display("%0d/%0d checks passed", checks_passed, checks_run);
    $finish;
  end

endmodule
